nibble_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 4-bit nibble CPU.
- Fetches 8-bit instructions from a synchronous program ROM and decodes them into ALU opcode and operand-select controls.
- Drives accumulator, data-RAM and output-port write enables.
- Captures the ALU carry/zero outputs into a flag register and resolves conditional jumps from it.
- Sits between program ROM, the ALU and the datapath registers. It is the producer of ALU controls and the consumer of ALU flags.

---
 rtl/nibble_pkg.sv | 65 ++++++
 rtl/nibble_sequencer_if.sv | 28 ++
 rtl/nibble_decode.sv | 35 +++
 rtl/nibble_sequencer.sv | 101 ++++++++++
 tb/tb_nibble_sequencer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_pkg.sv
// Shared types for the nibble CPU: ALU function codes, instruction opcodes,
// operand selects, sequencer states and the decoded control bundle.
package nibble_pkg;

  typedef enum logic [2:0] {
    ALU_OUT = 3'b000,
    ALU_CMP = 3'b001,
    ALU_LD  = 3'b010,
    ALU_ADD = 3'b011,
    ALU_NOR = 3'b100
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0, OP_JNC  = 4'h1, OP_CMPI = 4'h2, OP_CMPM = 4'h3,
    OP_LIT  = 4'h4, OP_IN   = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7,
    OP_JZ   = 4'h8, OP_NORI = 4'h9, OP_JNZ  = 4'hA, OP_NORM = 4'hB,
    OP_OUT  = 4'hC, OP_ADDI = 4'hD, OP_ADDM = 4'hE, OP_JMP  = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    BSEL_IMM  = 2'd0,
    BSEL_DMEM = 2'd1,
    BSEL_INP  = 2'd2
  } bsel_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_JUMP
  } state_e;

  typedef enum logic [2:0] {
    COND_C,
    COND_NC,
    COND_Z,
    COND_NZ,
    COND_ALWAYS
  } cond_e;

  typedef struct packed {
    alu_op_e alu;
    bsel_e   bsel;
    logic    acc_we;
    logic    dmem_we;
    logic    out_we;
    logic    flags_we;
    logic    is_jump;
    cond_e   cond;
  } ctrl_t;

  function automatic logic cond_met(cond_e c, logic cf, logic zf);
    logic r;
    r = 1'b1;
    case (c)
      COND_C:  r = cf;
      COND_NC: r = ~cf;
      COND_Z:  r = zf;
      COND_NZ: r = ~zf;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nibble_sequencer_if.sv
// ROM / ALU / datapath-control bundle between the sequencer and the rest of the CPU.
interface nibble_sequencer_if #(parameter int unsigned PC_W = 12);
  logic [PC_W-1:0] rom_addr;
  logic [7:0]      rom_data;
  logic [2:0]      alu_opcode;
  logic [1:0]      alu_b_sel;
  logic [3:0]      imm;
  logic            alu_carry;
  logic            alu_zero;
  logic            acc_we;
  logic            dmem_we;
  logic            out_we;
  logic            carry_flag;
  logic            zero_flag;
  logic            jump_taken;

  modport master (
    output rom_addr, alu_opcode, alu_b_sel, imm,
    output acc_we, dmem_we, out_we, carry_flag, zero_flag, jump_taken,
    input  rom_data, alu_carry, alu_zero
  );

  modport slave (
    input  rom_addr, alu_opcode, alu_b_sel, imm,
    input  acc_we, dmem_we, out_we, carry_flag, zero_flag, jump_taken,
    output rom_data, alu_carry, alu_zero
  );
endinterface

// File: rtl/nibble_decode.sv
// Combinational instruction decoder: ir[7:4] to ALU controls, strobes and jump condition.
module nibble_decode
  import nibble_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu      = ALU_OUT;
    ctrl.bsel     = BSEL_IMM;
    ctrl.cond     = COND_ALWAYS;
    case (op_e'(op))
      OP_JC:   begin ctrl.is_jump = 1'b1; ctrl.cond = COND_C;  end
      OP_JNC:  begin ctrl.is_jump = 1'b1; ctrl.cond = COND_NC; end
      OP_JZ:   begin ctrl.is_jump = 1'b1; ctrl.cond = COND_Z;  end
      OP_JNZ:  begin ctrl.is_jump = 1'b1; ctrl.cond = COND_NZ; end
      OP_JMP:  begin ctrl.is_jump = 1'b1; ctrl.cond = COND_ALWAYS; end
      OP_CMPI: begin ctrl.alu = ALU_CMP; ctrl.flags_we = 1'b1; end
      OP_CMPM: begin ctrl.alu = ALU_CMP; ctrl.bsel = BSEL_DMEM; ctrl.flags_we = 1'b1; end
      OP_LIT:  begin ctrl.alu = ALU_LD;  ctrl.acc_we = 1'b1; end
      OP_IN:   begin ctrl.alu = ALU_LD;  ctrl.bsel = BSEL_INP;  ctrl.acc_we = 1'b1; end
      OP_LD:   begin ctrl.alu = ALU_LD;  ctrl.bsel = BSEL_DMEM; ctrl.acc_we = 1'b1; end
      OP_ST:   begin ctrl.alu = ALU_OUT; ctrl.dmem_we = 1'b1; end
      OP_OUT:  begin ctrl.alu = ALU_OUT; ctrl.out_we = 1'b1; end
      OP_NORI: begin ctrl.alu = ALU_NOR; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      OP_NORM: begin ctrl.alu = ALU_NOR; ctrl.bsel = BSEL_DMEM; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      OP_ADDI: begin ctrl.alu = ALU_ADD; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      OP_ADDM: begin ctrl.alu = ALU_ADD; ctrl.bsel = BSEL_DMEM; ctrl.acc_we = 1'b1; ctrl.flags_we = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_sequencer.sv
// Fetch/decode/execute controller: 3 cycles per instruction, 4 for two-byte jumps.
module nibble_sequencer
  import nibble_pkg::*;
#(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  nibble_sequencer_if.master bus
);

  if (ROM_LAT != 1) begin : g_bad_rom_lat
    $error("nibble_sequencer: only ROM_LAT = 1 is supported");
  end

  state_e          state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [7:0]      ir, ir_nx;
  logic            carry, carry_nx;
  logic            zero, zero_nx;
  logic            live;
  logic [11:0]     target;
  ctrl_t           ctrl;

  nibble_decode u_decode (
    .op   (ir[7:4]),
    .ctrl (ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (en) begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      carry <= carry_nx;
      zero  <= zero_nx;
    end
  end

  // Strobes are gated by reset too, so an aborted jump never pulses jump_taken.
  assign live   = en & ~reset;
  assign target = {ir[3:0], bus.rom_data};

  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    ir_nx          = ir;
    carry_nx       = carry;
    zero_nx        = zero;
    bus.alu_opcode = ALU_OUT;
    bus.alu_b_sel  = BSEL_IMM;
    bus.acc_we     = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.out_we     = 1'b0;
    bus.jump_taken = 1'b0;
    case (state)
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: begin
        ir_nx    = bus.rom_data;
        pc_nx    = pc + PC_W'(1);
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        bus.alu_opcode = ctrl.alu;
        bus.alu_b_sel  = ctrl.bsel;
        bus.acc_we     = ctrl.acc_we & live;
        bus.dmem_we    = ctrl.dmem_we & live;
        bus.out_we     = ctrl.out_we & live;
        if (ctrl.flags_we) begin
          carry_nx = bus.alu_carry;
          zero_nx  = bus.alu_zero;
        end
        state_nx = ctrl.is_jump ? ST_JUMP : ST_FETCH;
      end
      ST_JUMP: begin
        if (cond_met(ctrl.cond, carry, zero)) begin
          pc_nx          = PC_W'(target);
          bus.jump_taken = live;
        end else begin
          pc_nx = pc + PC_W'(1);
        end
        state_nx = ST_FETCH;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  assign bus.rom_addr   = pc;
  assign bus.imm        = ir[3:0];
  assign bus.carry_flag = carry;
  assign bus.zero_flag  = zero;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Randomized bench: an instruction-level reference model expands each instruction
// into its expected cycle trace, which is consumed one enabled cycle at a time.
module tb_nibble_sequencer;

  localparam int unsigned PC_W  = 12;
  localparam int unsigned DEPTH = 1 << PC_W;

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  op;
    logic [1:0]  bsel;
    logic [3:0]  imm;
    logic        acc;
    logic        dmem;
    logic        out;
    logic        cf;
    logic        zf;
    logic        jt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic en;

  nibble_sequencer_if #(.PC_W(PC_W)) bus ();

  nibble_sequencer #(.PC_W(PC_W), .ROM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [DEPTH];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Per-op row: {alu[2:0], bsel[1:0], acc, dmem, out, flags}; jump rows are all zero.
  logic [8:0] tab [16] = '{
    9'b000_00_0000,  // JC
    9'b000_00_0000,  // JNC
    9'b001_00_0001,  // CMPI
    9'b001_01_0001,  // CMPM
    9'b010_00_1000,  // LIT
    9'b010_10_1000,  // IN
    9'b010_01_1000,  // LD
    9'b000_00_0100,  // ST
    9'b000_00_0000,  // JZ
    9'b100_00_1001,  // NORI
    9'b000_00_0000,  // JNZ
    9'b100_01_1001,  // NORM
    9'b000_00_0010,  // OUT
    9'b011_00_1001,  // ADDI
    9'b011_01_1001,  // ADDM
    9'b000_00_0000   // JMP
  };

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  exp_t        q[$];
  logic [11:0] m_pc;
  logic        m_c, m_z;
  logic [3:0]  m_imm;
  logic        cur_c, cur_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc  = '0;
    m_c   = 1'b0;
    m_z   = 1'b0;
    m_imm = '0;
  endtask

  task automatic build_instr();
    logic [11:0] nxt;
    logic [7:0]  b0, b1;
    logic [3:0]  op;
    logic [8:0]  row;
    logic        jmp, taken;
    exp_t        e;
    nxt   = m_pc + 12'd1;
    b0    = rom[m_pc];
    b1    = rom[nxt];
    op    = b0[7:4];
    row   = tab[op];
    cur_c = 1'($urandom_range(0, 1));
    cur_z = 1'($urandom_range(0, 1));
    jmp   = (op == 4'h0) || (op == 4'h1) || (op == 4'h8) || (op == 4'hA) || (op == 4'hF);
    e      = '0;
    e.addr = m_pc;
    e.imm  = m_imm;
    e.cf   = m_c;
    e.zf   = m_z;
    q.push_back(e);  // fetch
    q.push_back(e);  // decode
    e.addr = nxt;
    e.imm  = b0[3:0];
    e.op   = row[8:6];
    e.bsel = row[5:4];
    e.acc  = row[3];
    e.dmem = row[2];
    e.out  = row[1];
    q.push_back(e);  // execute
    if (jmp) begin
      case (op)
        4'h0:    taken = m_c;
        4'h1:    taken = ~m_c;
        4'h8:    taken = m_z;
        4'hA:    taken = ~m_z;
        default: taken = 1'b1;
      endcase
      e.jt = taken;
      q.push_back(e);
      m_pc = taken ? {b0[3:0], b1} : m_pc + 12'd2;
    end else begin
      m_pc = nxt;
      if (row[0]) begin
        m_c = cur_c;
        m_z = cur_z;
      end
    end
    m_imm = b0[3:0];
  endtask

  task automatic cycle(input logic rst_v, input logic en_v);
    exp_t e;
    @(negedge clk);
    reset = rst_v;
    en    = en_v;
    if (q.size() == 0) build_instr();
    e = q[0];
    bus.alu_carry = cur_c;
    bus.alu_zero  = cur_z;
    if (rst_v || !en_v) begin
      e.acc  = 1'b0;
      e.dmem = 1'b0;
      e.out  = 1'b0;
      e.jt   = 1'b0;
    end
    #1;
    check("rom_addr",   32'(bus.rom_addr),   32'(e.addr));
    check("alu_opcode", 32'(bus.alu_opcode), 32'(e.op));
    check("alu_b_sel",  32'(bus.alu_b_sel),  32'(e.bsel));
    check("imm",        32'(bus.imm),        32'(e.imm));
    check("acc_we",     32'(bus.acc_we),     32'(e.acc));
    check("dmem_we",    32'(bus.dmem_we),    32'(e.dmem));
    check("out_we",     32'(bus.out_we),     32'(e.out));
    check("carry_flag", 32'(bus.carry_flag), 32'(e.cf));
    check("zero_flag",  32'(bus.zero_flag),  32'(e.zf));
    check("jump_taken", 32'(bus.jump_taken), 32'(e.jt));
    @(posedge clk);
    if (rst_v) model_reset();
    else if (en_v) void'(q.pop_front());
  endtask

  initial begin
    logic forced;
    reset         = 1'b1;
    en            = 1'b1;
    bus.alu_carry = 1'b0;
    bus.alu_zero  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);

    // Loop 0 -> JMP 0xFFE -> LIT -> OUT at 0xFFF -> wraps to 0; first taken jump is reset mid-way.
    rom[0]      = 8'hFF;
    rom[1]      = 8'hFE;
    rom[12'hFFE] = 8'h4A;
    rom[12'hFFF] = 8'hC0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    model_reset();
    forced = 1'b0;
    for (int unsigned i = 0; i < 60; i++) begin
      logic r;
      if (q.size() == 0) build_instr();
      r = !forced && q[0].jt;
      if (r) forced = 1'b1;
      cycle(r, 1'b1);
    end

    for (int unsigned i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    cycle(1'b1, 1'b1);
    for (int unsigned i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
